// File: rtl/fcvt_s_wu_seq_if.sv
// ----------------------------------------------------------------------------
// fcvt_s_wu_seq_if
// Request/response bundle for the sequential integer-to-binary32 converter.
//   start     : request pulse, honoured only while busy=0
//   rs1       : 32-bit integer operand
//   signed_op : 1 = two's complement operand, 0 = unsigned
//   rm        : rounding mode (RNE/RTZ/RDN/RUP/RMM, others act as RNE)
//   busy      : conversion in flight
//   done      : one-cycle result-valid pulse
//   out       : binary32 result, held until the next done
//   nx        : inexact flag, held with out
// master = requester side, slave = converter side.
// ----------------------------------------------------------------------------
interface fcvt_s_wu_seq_if;
    logic        start;
    logic [31:0] rs1;
    logic        signed_op;
    logic [2:0]  rm;
    logic        busy;
    logic        done;
    logic [31:0] out;
    logic        nx;

    modport master (output start, rs1, signed_op, rm,
                    input  busy, done, out, nx);
    modport slave  (input  start, rs1, signed_op, rm,
                    output busy, done, out, nx);
endinterface

// File: rtl/fcvt_s_wu_seq.sv
// ----------------------------------------------------------------------------
// fcvt_s_wu_seq
// Multi-cycle FCVT.S.WU / FCVT.S.W. The operand magnitude is captured on
// start, left-normalised one bit per cycle, then rounded in a single cycle.
//   clk    : rising-edge clock
//   resetn : asynchronous active-low reset; aborts a conversion in flight
//   bus    : fcvt_s_wu_seq_if.slave (start/rs1/signed_op/rm in,
//            busy/done/out/nx out)
// Latency: 1 cycle for a zero operand, leading_zeros+3 edges otherwise.
// ----------------------------------------------------------------------------
module fcvt_s_wu_seq (
    input  logic              clk,
    input  logic              resetn,
    fcvt_s_wu_seq_if.slave    bus
);

    typedef enum logic [1:0] {S_IDLE, S_NORM, S_ROUND} state_t;

    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    state_t      r_state;
    logic [31:0] r_m;       // magnitude being normalised
    logic [7:0]  r_e;       // biased exponent, tracks the shifts
    logic        r_sign;
    logic [2:0]  r_rm;
    logic [31:0] r_out;
    logic        r_nx;
    logic        r_done;

    logic        w_sign;
    logic [31:0] w_mag;
    logic        w_g;
    logic        w_s;
    logic        w_inc;
    logic [23:0] w_sum;
    logic [7:0]  w_e_rnd;

    // Two's complement negate; 0x80000000 maps onto itself, which is the
    // correct magnitude for INT_MIN.
    assign w_sign = bus.signed_op & bus.rs1[31];
    assign w_mag  = w_sign ? (~bus.rs1 + 32'd1) : bus.rs1;

    // NOTE: every always_comb output gets a default first so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        w_g   = r_m[7];
        w_s   = |r_m[6:0];
        w_inc = w_g & (w_s | r_m[8]);           // RNE and reserved modes
        case (r_rm)
            RM_RTZ:  w_inc = 1'b0;
            RM_RDN:  w_inc = r_sign & (w_g | w_s);
            RM_RUP:  w_inc = ~r_sign & (w_g | w_s);
            RM_RMM:  w_inc = w_g;
            default: ;
        endcase
        // A carry out of the fraction leaves sum[22:0] all zero, so only the
        // exponent needs the adjustment. e <= 159, so no overflow is possible.
        w_sum   = {1'b0, r_m[30:8]} + {23'd0, w_inc};
        w_e_rnd = r_e + {7'd0, w_sum[23]};
    end

    // NOTE: all datapath registers are reset along with the FSM so outputs
    // and held state are defined from the first cycle after reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_m     <= '0;
            r_e     <= '0;
            r_sign  <= 1'b0;
            r_rm    <= '0;
            r_out   <= '0;
            r_nx    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register updates from pre-edge values regardless of order.
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.rs1 == 32'd0) begin
                            r_out  <= '0;
                            r_nx   <= 1'b0;
                            r_done <= 1'b1;
                        end else begin
                            r_sign  <= w_sign;
                            r_m     <= w_mag;
                            r_e     <= 8'd158;
                            r_rm    <= bus.rm;
                            r_state <= S_NORM;
                        end
                    end
                end
                S_NORM: begin
                    if (r_m[31]) begin
                        r_state <= S_ROUND;
                    end else begin
                        r_m <= r_m << 1;
                        r_e <= r_e - 8'd1;
                    end
                end
                S_ROUND: begin
                    r_out   <= {r_sign, w_e_rnd, w_sum[22:0]};
                    r_nx    <= w_g | w_s;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy = (r_state != S_IDLE);
    assign bus.done = r_done;
    assign bus.out  = r_out;
    assign bus.nx   = r_nx;

endmodule

// File: tb/tb_fcvt_s_wu_seq.sv
// ----------------------------------------------------------------------------
// tb_fcvt_s_wu_seq
// Directed bench for fcvt_s_wu_seq. Expected {nx,out} words are queued when a
// request is issued and compared when done pulses; latency, handshake and
// reset behaviour are checked at the points where they occur.
// ----------------------------------------------------------------------------
module tb_fcvt_s_wu_seq;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    fcvt_s_wu_seq_if bus ();

    fcvt_s_wu_seq dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    localparam logic [2:0] RNE = 3'b000, RTZ = 3'b001, RDN = 3'b010,
                           RUP = 3'b011, RMM = 3'b100;

    int          n_cmp  = 0;
    int          n_fail = 0;
    int          n_done = 0;
    int          n_acc  = 0;
    string       step   = "init";
    logic [32:0] sb_q[$];          // {nx, out}

    task automatic check(input string tag, input logic [32:0] obs,
                         input logic [32:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s/%s: observed %h expected %h", step, tag, obs, exp);
        end
    endtask

    // Reference conversion: exact integer truncation plus remainder compare.
    function automatic logic [32:0] model(input logic [31:0] x,
                                          input logic sop,
                                          input logic [2:0] rm);
        logic        sign;
        logic [63:0] mag, mant, rem, half;
        int          p, sh, exp_b;
        logic        up, nz;
        sign = sop & x[31];
        mag  = {32'd0, sign ? (~x + 32'd1) : x};
        if (mag == 64'd0) return 33'd0;
        p = 31;
        while (!mag[p]) p--;
        if (p <= 23) begin
            mant = mag << (23 - p);
            rem  = 64'd0;
            half = 64'd1;
        end else begin
            sh   = p - 23;
            mant = mag >> sh;
            rem  = mag & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
        end
        nz = (rem != 64'd0);
        case (rm)
            RTZ:     up = 1'b0;
            RDN:     up = sign & nz;
            RUP:     up = ~sign & nz;
            RMM:     up = (rem >= half) & nz;
            default: up = (rem > half) | ((rem == half) & nz & mant[0]);
        endcase
        mant  = mant + {63'd0, up};
        exp_b = 127 + p;
        if (mant[24]) begin
            mant  = mant >> 1;
            exp_b = exp_b + 1;
        end
        return {nz, sign, 8'(exp_b), mant[22:0]};
    endfunction

    function automatic int latency(input logic [31:0] x, input logic sop);
        logic [31:0] mag;
        int          lz;
        mag = (sop & x[31]) ? (~x + 32'd1) : x;
        if (mag == 32'd0) return 1;
        lz = 0;
        while (!mag[31 - lz]) lz++;
        return lz + 3;
    endfunction

    // Result monitor: every done must match the oldest queued expectation.
    always @(negedge clk) begin
        if (resetn === 1'b1 && bus.done === 1'b1) begin
            n_done++;
            if (sb_q.size() == 0) begin
                check("spurious_done", {32'd0, bus.done}, 33'd0);
            end else begin
                logic [32:0] e;
                e = sb_q.pop_front();
                check("out", {1'b0, bus.out}, {1'b0, e[31:0]});
                check("nx",  {32'd0, bus.nx}, {32'd0, e[32]});
            end
        end
    end

    // Called just after a falling edge; the next rising edge is the start edge.
    task automatic issue(input logic [31:0] x, input logic sop,
                         input logic [2:0] rm, input logic [32:0] exp,
                         input bit push);
        bus.start     = 1'b1;
        bus.rs1       = x;
        bus.signed_op = sop;
        bus.rm        = rm;
        if (push) begin
            sb_q.push_back(exp);
            n_acc++;
        end
    endtask

    // Counts falling edges (lat0 already elapsed) until done, bounded.
    task automatic wait_done(input int exp_lat, input int lat0);
        int lat;
        bit seen;
        lat  = lat0;
        seen = 1'b0;
        for (int i = 0; i < 45 && !seen; i++) begin
            @(negedge clk);
            lat++;
            bus.start = 1'b0;
            if (bus.done === 1'b1) seen = 1'b1;
        end
        check("latency", 33'(lat), 33'(exp_lat));
    endtask

    task automatic conv(input string name, input logic [31:0] x,
                        input logic sop, input logic [2:0] rm,
                        input logic [32:0] exp, input int exp_lat);
        step = name;
        issue(x, sop, rm, exp, 1'b1);
        wait_done(exp_lat, 0);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.rs1       = '0;
        bus.signed_op = 1'b0;
        bus.rm        = RNE;
        resetn        = 1'b0;
        repeat (3) @(negedge clk);

        step = "reset";
        check("busy", {32'd0, bus.busy}, 33'd0);
        check("done", {32'd0, bus.done}, 33'd0);
        check("out",  {1'b0, bus.out},   33'd0);
        check("nx",   {32'd0, bus.nx},   33'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Magnitudes at both ends, zero operand
        conv("one_rne",     32'h0000_0001, 1'b0, RNE, {1'b0, 32'h3F80_0000}, 34);
        conv("zero_u",      32'h0000_0000, 1'b0, RNE, 33'd0,                 1);
        conv("ffff_rne",    32'hFFFF_FFFF, 1'b0, RNE, {1'b1, 32'h4F80_0000}, 3);
        conv("ffff_rtz",    32'hFFFF_FFFF, 1'b0, RTZ, {1'b1, 32'h4F7F_FFFF}, 3);
        // Exact tie on the guard bit
        conv("tie_rne",     32'h0100_0001, 1'b0, RNE, {1'b1, 32'h4B80_0000}, 10);
        conv("tie_rup",     32'h0100_0001, 1'b0, RUP, {1'b1, 32'h4B80_0001}, 10);
        conv("tie_rmm",     32'h0100_0001, 1'b0, RMM, {1'b1, 32'h4B80_0001}, 10);
        conv("tie_rdn",     32'h0100_0001, 1'b0, RDN, {1'b1, 32'h4B80_0000}, 10);
        // Signed operands
        conv("s_m1",        32'hFFFF_FFFF, 1'b1, RNE, {1'b0, 32'hBF80_0000}, 34);
        conv("s_min",       32'h8000_0000, 1'b1, RNE, {1'b0, 32'hCF00_0000}, 3);
        conv("s_rdn",       32'hFEFF_FFFF, 1'b1, RDN, {1'b1, 32'hCB80_0001}, 10);
        conv("s_rup",       32'hFEFF_FFFF, 1'b1, RUP, {1'b1, 32'hCB80_0000}, 10);
        conv("zero_s",      32'h0000_0000, 1'b1, RTZ, 33'd0,                 1);
        conv("rsvd_rm",     32'h0100_0003, 1'b0, 3'b111, {1'b1, 32'h4B80_0002}, 10);

        // Start while busy must be ignored entirely
        step = "busy_ignore";
        issue(32'h0000_0001, 1'b0, RNE, {1'b0, 32'h3F80_0000}, 1'b1);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        issue(32'hFFFF_FFFF, 1'b1, RUP, 33'd0, 1'b0);
        check("busy", {32'd0, bus.busy}, 33'd1);
        wait_done(34, 4);

        // Back-to-back: each new start is issued in the done cycle
        step = "b2b_a";
        issue(32'hFFFF_FFFF, 1'b0, RNE, {1'b1, 32'h4F80_0000}, 1'b1);
        wait_done(3, 0);
        step = "b2b_b";
        issue(32'h0100_0001, 1'b0, RUP, {1'b1, 32'h4B80_0001}, 1'b1);
        wait_done(10, 0);
        step = "b2b_zero";
        issue(32'h0000_0000, 1'b0, RNE, 33'd0, 1'b1);
        wait_done(1, 0);
        step = "b2b_c";
        issue(32'h8000_0000, 1'b1, RTZ, {1'b0, 32'hCF00_0000}, 1'b1);
        wait_done(3, 0);

        // Pseudo-random operands against the reference model
        for (int i = 0; i < 12; i++) begin
            logic [31:0] x;
            logic        sop;
            logic [2:0]  rm;
            x   = $urandom() >> $urandom_range(0, 31);
            sop = 1'($urandom_range(0, 1));
            rm  = 3'($urandom_range(0, 5));
            conv($sformatf("rand%0d", i), x, sop, rm, model(x, sop, rm),
                 latency(x, sop));
        end

        // Reset mid-conversion: outputs clear and no done ever follows
        step = "reset_mid";
        issue(32'h0000_0001, 1'b0, RNE, 33'd0, 1'b0);
        repeat (5) @(negedge clk) bus.start = 1'b0;
        check("busy_before", {32'd0, bus.busy}, 33'd1);
        resetn = 1'b0;
        #1;
        check("busy", {32'd0, bus.busy}, 33'd0);
        check("out",  {1'b0, bus.out},   33'd0);
        check("nx",   {32'd0, bus.nx},   33'd0);
        check("done", {32'd0, bus.done}, 33'd0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (40) @(negedge clk);
        check("busy_after", {32'd0, bus.busy}, 33'd0);

        step = "final";
        check("done_count", 33'(n_done), 33'(n_acc));
        check("queue_empty", 33'(sb_q.size()), 33'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fcvt_s_wu_seq.md
Name: fcvt_s_wu_seq

Overview:
Multi-cycle integer-to-single-precision converter. Implements FCVT.S.WU, and FCVT.S.W when signed_op=1. It is the reverse of the existing float-to-unsigned converter in the FPU datapath. The block accepts a 32-bit integer on a start pulse, normalises it one bit per cycle, rounds per rm, and returns an IEEE-754 binary32 result with a done pulse and an inexact flag.

Parameters:
None.

Ports:
clk  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
start  input  1  request; sampled only when busy=0
rs1  input  32  integer operand, captured on the start edge
signed_op  input  1  1 = rs1 is two's complement (FCVT.S.W); 0 = unsigned (FCVT.S.WU)
rm  input  3  rounding mode, captured on start: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101-111 treated as RNE
busy  output  1  high while a conversion is in flight
done  output  1  one-cycle pulse; out and nx valid from this cycle
out  output  32  binary32 result; holds until next done
nx  output  1  inexact flag; holds with out

Behaviour:
- Reset (async, resetn=0): state=IDLE, out=0, nx=0, done=0, busy=0. Reset mid-conversion aborts it; no done is produced.
- busy = (state != IDLE), combinational from state. A start while busy=1 is ignored, with no side effects.
- FSM states: IDLE, NORM, ROUND.
- IDLE, start=1, operand non-zero (edge E0):
  - sign = signed_op & rs1[31].
  - m = sign ? -rs1 : rs1, in 32 bits. 0x80000000 signed gives m=0x80000000.
  - e = 158 (127+31); latch rm; go to NORM.
- IDLE, start=1, rs1=0 (either signedness): at E0 set out=0x00000000, nx=0, done=1 next cycle; stay IDLE. Latency is 1 cycle.
- NORM, each edge:
  - m[31]=1: go to ROUND.
  - Otherwise: m <= m<<1, e <= e-1.
  - For lz leading zeros this takes lz+1 NORM edges.
- ROUND, one edge:
  - frac = m[30:8], g = m[7], s = |m[6:0], lsb = m[8].
  - Round-up condition inc:
    - RNE: g & (s | lsb)
    - RTZ: 0
    - RDN: sign & (g | s)
    - RUP: ~sign & (g | s)
    - RMM: g
  - {c, frac'} = frac + inc (24-bit sum). If c=1, frac'=0 and e=e+1.
  - Exponent never exceeds 159, so overflow and inf are impossible.
  - out <= {sign, e[7:0], frac'}; nx <= g | s; done <= 1; go to IDLE.
- done is high for exactly the cycle after the result edge, and is low otherwise.
- A new start in the done cycle is accepted, since state is IDLE.
- Latency for a non-zero operand: done is first visible lz+3 edges after E0 (max 34 for operand 1, min 3 for MSB set).
- No subnormals or NaNs can be generated. -0 is never produced.

Test Plan:
1. Reset mid-op: start with rs1=1, assert resetn=0 at cycle 5 -> busy=0, out=0, nx=0, no done pulse afterwards.
2. rs1=0x00000001, unsigned, RNE -> done at edge 34 after start, out=0x3F800000, nx=0.
   rs1=0 -> done after 1 cycle, out=0x00000000.
3. rs1=0xFFFFFFFF unsigned:
   - RNE -> out=0x4F800000, nx=1 (exponent carry), latency 3.
   - Same operand, RTZ -> out=0x4F7FFFFF, nx=1.
4. rs1=0x01000001 unsigned (tie):
   - RNE -> out=0x4B800000, nx=1.
   - RUP -> 0x4B800001.
   - RMM -> 0x4B800001.
   - RDN -> 0x4B800000.
5. Signed:
   - rs1=0xFFFFFFFF, signed_op=1 -> out=0xBF800000, nx=0.
   - rs1=0x80000000, signed_op=1 -> out=0xCF000000.
   - rs1=0xFEFFFFFF (-16777217), RDN -> 0xCB800001.
   - Same operand, RUP -> 0xCB800000.
6. Handshake:
   - start pulsed while busy (with different rs1) -> ignored; result matches the first operand.
   - start in the done cycle -> accepted; back-to-back results correct, with exactly one done per accepted start.
